cnn_ram_arbiter: RTL and testbench
==================================

Name: cnn_ram_arbiter

Overview:
Arbitrates the single-port 1-bit-wide CNN input RAM between two requesters. The write requester is the UART bit unpacker, which writes pixels sequentially. The read requester is the 3x3 window fetcher feeding cnn_core. The block also:
- Tracks the write high-water mark.
- Blocks reads of pixels not yet written (RAW hazard).
- Guarantees read forward progress with a starvation limit.
- Is cleared per frame by frame_clr (driven from tx_done).

Parameters:
ADDR_W, 10, RAM address width
DEPTH, 784, valid pixel locations (28x28); addresses >= DEPTH are out of bounds
STARVE_MAX, 4, consecutive cycles an eligible read may lose to writes before read gets priority

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
frame_clr  input  1  synchronous per-frame clear
wr_req  input  1  write request, held until granted
wr_addr  input  ADDR_W  write address
wr_data  input  1  write bit
wr_gnt  output  1  write accepted this cycle
rd_req  input  1  read request, held until granted
rd_addr  input  ADDR_W  read address
rd_gnt  output  1  read accepted this cycle
rd_valid  output  1  rd_data valid (1 cycle after rd_gnt)
rd_data  output  1  read bit
ram_we  output  1  RAM write enable
ram_addr  output  ADDR_W  RAM address
ram_din  output  1  RAM write data
ram_dout  input  1  RAM read data, registered, 1-cycle latency
wr_ptr  output  ADDR_W  count of sequential pixels written this frame
err_seq  output  1  sticky: write address was not equal to wr_ptr
err_oob  output  1  sticky: address >= DEPTH

Behaviour:
Reset values:
- All outputs 0.
- starve_cnt = 0.
- Read pipe empty.

Handshake:
- A transfer occurs in the cycle where req && gnt.
- gnt is combinational from req, addresses and registered state.
- At most one of wr_gnt/rd_gnt is high per cycle.

Read eligibility (rd_elig):
- rd_req && (rd_addr < wr_ptr || rd_addr >= DEPTH).
- A read with DEPTH > rd_addr >= wr_ptr is hazard-stalled: rd_gnt = 0, and the cycle does not count toward starvation.

Priority:
- Writes win by default.
- Reads win when rd_elig && starve_cnt == STARVE_MAX.
- starve_cnt:
  - Increments (saturating at STARVE_MAX) on each cycle rd_elig && wr_gnt.
  - Clears when rd_gnt is high or rd_elig is low.

Granted write:
- If wr_addr < DEPTH: ram_we = 1, ram_addr = wr_addr, ram_din = wr_data.
- If wr_addr == wr_ptr: wr_ptr increments next cycle.
- Else: wr_ptr is unchanged and err_seq is set.
- If wr_addr >= DEPTH: the request is consumed (wr_gnt = 1), there is no RAM access, and err_oob is set.

Granted read:
- If rd_addr < DEPTH: ram_we = 0, ram_addr = rd_addr.
- rd_valid = 1 next cycle; rd_data = ram_dout in that cycle.
- If rd_addr >= DEPTH: rd_gnt = 1, no RAM access, err_oob is set, and rd_valid = 1 next cycle with rd_data = 0.
- Back-to-back reads give rd_valid high on consecutive cycles.

Idle cycles: ram_we = 0 and ram_addr holds its last value.

wr_ptr bounds: wr_ptr saturates at DEPTH and never wraps.

frame_clr (same cycle):
- wr_gnt and rd_gnt are forced to 0, and no RAM access occurs.
- Next cycle: wr_ptr, starve_cnt, err_seq, err_oob and rd_valid are all 0.
- If frame_clr coincides with an in-flight read (rd_valid due next cycle), that rd_valid is suppressed.

Async reset mid-transfer: all state drops to the reset values immediately.

Optional Feature:
CNN_ARB_STATS_EN.
- When defined, the block adds these outputs, cleared by rst_n and frame_clr:
  - stat_wr_cnt [15:0]: granted writes.
  - stat_rd_cnt [15:0]: granted reads.
  - stat_stall_cnt [15:0]: cycles with rd_req && !rd_gnt.
- All three counters saturate at 16'hFFFF.
- When undefined, the ports and logic are absent and all other behaviour is identical.

Test Plan:
- Sequential fill: 10 writes, addr 0..9, wr_req always high, no reads -> wr_gnt every cycle; wr_ptr = 10; err_seq = 0.
- RAW hazard: wr_ptr = 3, rd_req with rd_addr = 5 -> rd_gnt = 0 and starve_cnt stays 0 until wr_ptr = 6; rd_gnt is asserted in the cycle wr_ptr becomes 6; rd_valid follows 1 cycle later with the written bit.
- Starvation: continuous writes plus eligible read (rd_addr = 0, wr_ptr = 1) -> reads lose 4 cycles, rd_gnt on the 5th cycle; wr_gnt = 0 that cycle; writes resume the next cycle.
- Out-of-order/out-of-bounds: write addr 7 with wr_ptr = 2 -> RAM written, wr_ptr stays 2, err_seq = 1. Write addr 800 -> wr_gnt = 1, ram_we = 0, err_oob = 1. Read addr 900 -> rd_valid = 1 with rd_data = 0.
- frame_clr: during a read grant with wr_ptr = 784 -> no rd_valid the next cycle; wr_ptr = 0; errors cleared; a following read of addr 0 is hazard-stalled.
- Back-to-back reads: addrs 0,1,2 after fill with pattern 1,0,1 -> rd_valid high for 3 consecutive cycles, rd_data = 1,0,1.

Source files
------------

// File: rtl/cnn_ram_arbiter.sv
// cnn_ram_arbiter: shares the single-port 1-bit CNN input RAM between the UART
// bit unpacker (sequential writer) and the 3x3 window fetcher (reader).
// Tracks the write high-water mark, stalls reads of unwritten pixels, bounds
// read starvation, and is cleared per frame by frame_clr.
// Optional statistics counters are enabled by defining CNN_ARB_STATS_EN.
module cnn_ram_arbiter #(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned DEPTH      = 784,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_clr,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_data,
  output logic              wr_gnt,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_gnt,
  output logic              rd_valid,
  output logic              rd_data,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_din,
  input  logic              ram_dout,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic              err_seq,
  output logic              err_oob
`ifdef CNN_ARB_STATS_EN
  ,
  output logic [15:0]       stat_wr_cnt,
  output logic [15:0]       stat_rd_cnt,
  output logic [15:0]       stat_stall_cnt
`endif
);

  localparam int unsigned StW = $clog2(STARVE_MAX + 1);
  localparam logic [ADDR_W:0] DepthX = (ADDR_W + 1)'(DEPTH);
  localparam logic [StW-1:0] StarveMaxC = StW'(STARVE_MAX);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [StW-1:0]    starve_q, starve_d;
  logic              err_seq_q, err_seq_d;
  logic              err_oob_q, err_oob_d;
  logic              rd_valid_q, rd_oob_q;
  logic [ADDR_W-1:0] ram_addr_q;

  logic wr_in_range, rd_in_range, rd_elig, rd_wins;

  // Eligibility and grant decision; frame_clr blocks every transfer.
  always_comb begin
    wr_in_range = {1'b0, wr_addr} < DepthX;
    rd_in_range = {1'b0, rd_addr} < DepthX;
    // Out-of-range reads are eligible so they can be consumed and flagged.
    rd_elig     = rd_req && (rd_addr < wr_ptr_q || !rd_in_range);
    rd_wins     = rd_elig && (starve_q == StarveMaxC);
    wr_gnt      = 1'b0;
    rd_gnt      = 1'b0;
    if (!frame_clr) begin
      if (wr_req && !rd_wins) begin
        wr_gnt = 1'b1;
      end else if (rd_elig) begin
        rd_gnt = 1'b1;
      end
    end
  end

  // RAM port drive; address holds its last value on idle cycles.
  always_comb begin
    ram_we   = wr_gnt && wr_in_range;
    ram_din  = ram_we && wr_data;
    ram_addr = ram_addr_q;
    if (ram_we) begin
      ram_addr = wr_addr;
    end else if (rd_gnt && rd_in_range) begin
      ram_addr = rd_addr;
    end
  end

  // Next-state for the write pointer, starvation counter and sticky errors.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    starve_d  = starve_q;
    err_seq_d = err_seq_q;
    err_oob_d = err_oob_q;
    if (frame_clr) begin
      wr_ptr_d  = '0;
      starve_d  = '0;
      err_seq_d = 1'b0;
      err_oob_d = 1'b0;
    end else begin
      if (wr_gnt) begin
        if (wr_addr == wr_ptr_q) begin
          // Saturate at DEPTH; a write at addr==DEPTH only flags out-of-bounds.
          if ({1'b0, wr_ptr_q} < DepthX) wr_ptr_d = wr_ptr_q + 1'b1;
        end else begin
          err_seq_d = 1'b1;
        end
        if (!wr_in_range) err_oob_d = 1'b1;
      end
      if (rd_gnt && !rd_in_range) err_oob_d = 1'b1;
      if (rd_gnt || !rd_elig) begin
        starve_d = '0;
      end else if (wr_gnt && starve_q != StarveMaxC) begin
        starve_d = starve_q + 1'b1;
      end
    end
  end

  // State registers, including the one-deep read return pipe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      starve_q   <= '0;
      err_seq_q  <= 1'b0;
      err_oob_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_oob_q   <= 1'b0;
      ram_addr_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      starve_q   <= starve_d;
      err_seq_q  <= err_seq_d;
      err_oob_q  <= err_oob_d;
      rd_valid_q <= rd_gnt;
      rd_oob_q   <= rd_gnt && !rd_in_range;
      ram_addr_q <= ram_addr;
    end
  end

  // Read return path; out-of-range reads return 0.
  always_comb begin
    rd_valid = rd_valid_q;
    rd_data  = rd_valid_q && !rd_oob_q && ram_dout;
    wr_ptr   = wr_ptr_q;
    err_seq  = err_seq_q;
    err_oob  = err_oob_q;
  end

`ifdef CNN_ARB_STATS_EN
  logic stall;
  assign stall = rd_req && !rd_gnt;

  // Saturating activity counters, cleared per frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_wr_cnt    <= '0;
      stat_rd_cnt    <= '0;
      stat_stall_cnt <= '0;
    end else if (frame_clr) begin
      stat_wr_cnt    <= '0;
      stat_rd_cnt    <= '0;
      stat_stall_cnt <= '0;
    end else begin
      if (wr_gnt && stat_wr_cnt != 16'hFFFF) stat_wr_cnt <= stat_wr_cnt + 16'd1;
      if (rd_gnt && stat_rd_cnt != 16'hFFFF) stat_rd_cnt <= stat_rd_cnt + 16'd1;
      if (stall && stat_stall_cnt != 16'hFFFF) stat_stall_cnt <= stat_stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cnn_ram_arbiter.sv
// Self-checking bench for cnn_ram_arbiter: directed scenarios followed by
// random traffic, compared against a pixel-level reference model. Read data
// expectations go through a scoreboard queue consumed by a monitor on rd_valid.
module tb_cnn_ram_arbiter;
  localparam int ADDR_W = 10;
  localparam int DEPTH = 784;
  localparam int STARVE_MAX = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic frame_clr = 1'b0, wr_req = 1'b0, wr_data = 1'b0, rd_req = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0, rd_addr = '0;
  logic wr_gnt, rd_gnt, rd_valid, rd_data, ram_we, ram_din, err_seq, err_oob;
  logic ram_dout = 1'b0;
  logic [ADDR_W-1:0] ram_addr, wr_ptr;
`ifdef CNN_ARB_STATS_EN
  logic [15:0] stat_wr_cnt, stat_rd_cnt, stat_stall_cnt;
`endif

  cnn_ram_arbiter #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst_n(rst_n), .frame_clr(frame_clr),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
    .wr_ptr(wr_ptr), .err_seq(err_seq), .err_oob(err_oob)
`ifdef CNN_ARB_STATS_EN
    ,
    .stat_wr_cnt(stat_wr_cnt), .stat_rd_cnt(stat_rd_cnt), .stat_stall_cnt(stat_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural single-port RAM with registered read.
  logic ram_mem [1024];
  initial for (int i = 0; i < 1024; i++) ram_mem[i] = 1'b0;
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_addr] <= ram_din;
    ram_dout <= ram_mem[ram_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model state.
  int m_ptr = 0;
  int m_starve = 0;
  int m_last = 0;
  bit m_eseq = 0, m_eoob = 0;
  bit m_mem [1024];
  initial for (int i = 0; i < 1024; i++) m_mem[i] = 1'b0;

  typedef struct { int due; bit d; } rd_exp_t;
  rd_exp_t exp_q[$];

  // Monitor: every rd_valid must match the oldest pending read, on time.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rd_valid) begin
        if (exp_q.size() == 0) begin
          check("rd_valid_unexpected", 1, 0);
        end else begin
          rd_exp_t e;
          e = exp_q.pop_front();
          check("rd_valid_timing", cyc, e.due);
          check("rd_data", int'(rd_data), int'(e.d));
        end
      end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        check("rd_valid_missing", 0, 1);
        void'(exp_q.pop_front());
      end
    end
  end

  // One clock of stimulus: drive, compare against the model, advance model.
  task automatic step(input bit fc, input bit wq, input int wa, input bit wd,
                      input bit rq, input int ra, output bit aw, output bit ar);
    bit elig, ew, er, ewe;
    int eaddr;
    frame_clr = fc; wr_req = wq; wr_addr = wa[ADDR_W-1:0]; wr_data = wd;
    rd_req = rq; rd_addr = ra[ADDR_W-1:0];
    #1;
    elig = rq && (ra < m_ptr || ra >= DEPTH);
    ew = 0; er = 0;
    if (!fc) begin
      if (wq && !(elig && m_starve == STARVE_MAX)) ew = 1;
      else if (elig) er = 1;
    end
    ewe = ew && (wa < DEPTH);
    eaddr = m_last;
    if (ewe) eaddr = wa;
    else if (er && ra < DEPTH) eaddr = ra;
    check("wr_gnt", int'(wr_gnt), int'(ew));
    check("rd_gnt", int'(rd_gnt), int'(er));
    check("ram_we", int'(ram_we), int'(ewe));
    check("ram_addr", int'(ram_addr), eaddr);
    if (ewe) check("ram_din", int'(ram_din), int'(wd));
    check("wr_ptr", int'(wr_ptr), m_ptr);
    check("err_seq", int'(err_seq), int'(m_eseq));
    check("err_oob", int'(err_oob), int'(m_eoob));
    aw = wr_gnt; ar = rd_gnt;
    m_last = eaddr;
    if (fc) begin
      m_ptr = 0; m_starve = 0; m_eseq = 0; m_eoob = 0;
    end else begin
      if (ew) begin
        if (wa < DEPTH) m_mem[wa] = wd;
        if (wa == m_ptr) begin
          if (m_ptr < DEPTH) m_ptr++;
        end else begin
          m_eseq = 1;
        end
        if (wa >= DEPTH) m_eoob = 1;
      end
      if (er) begin
        rd_exp_t e;
        e.due = cyc + 1;
        e.d = (ra < DEPTH) ? m_mem[ra] : 1'b0;
        exp_q.push_back(e);
        if (ra >= DEPTH) m_eoob = 1;
      end
      if (er || !elig) m_starve = 0;
      else if (ew && m_starve < STARVE_MAX) m_starve++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bit aw, ar;
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, aw, ar);
  endtask

  // Asynchronous reset asserted between clock edges.
  task automatic async_reset();
    frame_clr = 0; wr_req = 0; rd_req = 0;
    rst_n = 1'b0;
    #1;
    check("arst_wr_ptr", int'(wr_ptr), 0);
    check("arst_rd_valid", int'(rd_valid), 0);
    check("arst_errs", int'({err_seq, err_oob}), 0);
    m_ptr = 0; m_starve = 0; m_eseq = 0; m_eoob = 0; m_last = 0;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    bit aw, ar;
    int wa;
    bit pw, pr, cwq, cwd, crq, fc;
    int cwa, cra;

    // Reset values with idle inputs.
    #2;
    check("rst_outputs", int'({wr_gnt, rd_gnt, rd_valid, rd_data, ram_we, ram_din,
                              err_seq, err_oob}), 0);
    check("rst_ram_addr", int'(ram_addr), 0);
    check("rst_wr_ptr", int'(wr_ptr), 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // Sequential fill 0..9 with pattern 1,0,1,...
    for (int i = 0; i < 10; i++) begin
      step(0, 1, i, (i % 2 == 0), 0, 0, aw, ar);
      check("fill_wr_gnt", int'(aw), 1);
    end
    check("fill_wr_ptr", int'(wr_ptr), 10);
    check("fill_err_seq", int'(err_seq), 0);

    // Back-to-back reads 0,1,2 expecting 1,0,1.
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 1, i, aw, ar);
      check("b2b_rd_gnt", int'(ar), 1);
    end
    idle(2);

    // Starvation: four lost cycles, then the read wins, then writes resume.
    wa = 10;
    for (int k = 0; k < 5; k++) begin
      step(0, 1, wa, 1, 1, 0, aw, ar);
      check("starve_wr_gnt", int'(aw), (k < 4) ? 1 : 0);
      check("starve_rd_gnt", int'(ar), (k < 4) ? 0 : 1);
      if (aw) wa++;
    end
    step(0, 1, wa, 1, 0, 0, aw, ar);
    check("starve_wr_resume", int'(aw), 1);
    idle(2);

    // RAW hazard: read of addr 5 stalls until pixel 5 is written.
    step(1, 0, 0, 0, 0, 0, aw, ar);
    for (int i = 0; i < 3; i++) step(0, 1, i, 0, 0, 0, aw, ar);
    for (int i = 0; i < 2; i++) begin
      step(0, 0, 0, 0, 1, 5, aw, ar);
      check("raw_stall", int'(ar), 0);
    end
    for (int i = 3; i < 6; i++) begin
      step(0, 1, i, (i == 5), 1, 5, aw, ar);
      check("raw_stall_wr", int'(ar), 0);
    end
    step(0, 0, 0, 0, 1, 5, aw, ar);
    check("raw_release", int'(ar), 1);
    idle(2);

    // Out-of-order and out-of-bounds accesses.
    step(1, 0, 0, 0, 0, 0, aw, ar);
    step(0, 1, 0, 1, 0, 0, aw, ar);
    step(0, 1, 1, 1, 0, 0, aw, ar);
    step(0, 1, 7, 1, 0, 0, aw, ar);
    check("ooo_wr_ptr", int'(wr_ptr), 2);
    check("ooo_err_seq", int'(err_seq), 1);
    step(0, 1, 800, 1, 0, 0, aw, ar);
    check("oob_wr_gnt", int'(aw), 1);
    check("oob_err_oob", int'(err_oob), 1);
    step(0, 0, 0, 0, 1, 900, aw, ar);
    check("oob_rd_gnt", int'(ar), 1);
    idle(2);

    // Full frame, then frame_clr alongside a read request.
    step(1, 0, 0, 0, 0, 0, aw, ar);
    for (int i = 0; i < DEPTH; i++) step(0, 1, i, 1'($urandom), 0, 0, aw, ar);
    check("full_wr_ptr", int'(wr_ptr), DEPTH);
    step(0, 1, DEPTH, 1, 0, 0, aw, ar);
    check("sat_wr_ptr", int'(wr_ptr), DEPTH);
    step(1, 1, 0, 1, 1, 0, aw, ar);
    check("clr_no_gnt", int'({aw, ar}), 0);
    check("clr_wr_ptr", int'(wr_ptr), 0);
    check("clr_errs", int'({err_seq, err_oob}), 0);
    step(0, 0, 0, 0, 1, 0, aw, ar);
    check("clr_rd_stalled", int'(ar), 0);
    idle(2);

    // Random traffic; requests are held until granted.
    pw = 0; pr = 0; cwq = 0; cwd = 0; crq = 0; cwa = 0; cra = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        async_reset();
        pw = 0; pr = 0;
      end
      if (!pw) begin
        int r;
        r = $urandom_range(0, 19);
        cwq = ($urandom_range(0, 3) != 0);
        cwd = 1'($urandom);
        if (r < 16 && m_ptr < DEPTH) cwa = m_ptr;
        else if (r < 18) cwa = $urandom_range(0, DEPTH - 1);
        else cwa = $urandom_range(DEPTH, 1023);
      end
      if (!pr) begin
        int r;
        r = $urandom_range(0, 19);
        crq = 1'($urandom);
        if (r < 14) cra = $urandom_range(0, (m_ptr > 0) ? m_ptr - 1 : 0);
        else if (r < 17) cra = (m_ptr + $urandom_range(0, 3) < DEPTH) ?
                               m_ptr + $urandom_range(0, 3) : DEPTH - 1;
        else cra = $urandom_range(DEPTH, 1023);
      end
      fc = ($urandom_range(0, 999) == 0);
      step(fc, cwq, cwa, cwd, crq, cra, aw, ar);
      pw = cwq && !aw;
      pr = crq && !ar;
    end
    idle(3);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
